// File: rtl/mc_ctrl_fsm_if.sv
// Memory handshake bundle between the multicycle control FSM and the shared memory.
// The FSM side uses the master modport; the memory model uses the slave modport.
interface mc_ctrl_fsm_if;
    logic mem_req;
    logic mem_we;
    logic iord;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output iord, input mem_ready);
    modport slave  (input mem_req, input mem_we, input iord, output mem_ready);
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control FSM with req/ready memory handshake and a stall watchdog.
// Define MC_CTRL_BNE_EN to add the BNE state and the branch_ne output.
module mc_ctrl_fsm #(
    parameter int WAIT_W   = 8,
    parameter int MAX_WAIT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [5:0]    opcode,
    mc_ctrl_fsm_if.master mem,
    output logic          ir_we,
    output logic          pc_we,
    output logic          branch,
`ifdef MC_CTRL_BNE_EN
    output logic          branch_ne,
`endif
    output logic [1:0]    pc_src,
    output logic          alu_src_a,
    output logic [1:0]    alu_src_b,
    output logic [1:0]    alu_op,
    output logic          we_reg,
    output logic [1:0]    reg_dst,
    output logic [1:0]    dm2reg,
    output logic [3:0]    state,
    output logic          illegal,
    output logic          timeout
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BEQ    = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11,
        JAL    = 4'd12,
        BNE    = 4'd13,
        TRAP   = 4'd15
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
`ifdef MC_CTRL_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif
    localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              illegal_q, illegal_d;
    logic              timeout_q, timeout_d;
    logic              req_c, we_c, iord_c;
    logic              stall;
    logic [WAIT_W-1:0] wait_inc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            wait_cnt_q <= '0;
            illegal_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            illegal_q  <= illegal_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        illegal_d  = illegal_q;
        timeout_d  = timeout_q;
        req_c      = 1'b0;
        we_c       = 1'b0;
        iord_c     = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        branch     = 1'b0;
        pc_src     = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        we_reg     = 1'b0;
        reg_dst    = 2'b00;
        dm2reg     = 2'b00;
`ifdef MC_CTRL_BNE_EN
        branch_ne  = 1'b0;
`endif
        state      = state_q;
        illegal    = illegal_q;
        timeout    = timeout_q;

        case (state_q)
            FETCH: begin
                req_c     = 1'b1;
                alu_src_b = 2'b01;
                ir_we     = mem.mem_ready;
                pc_we     = mem.mem_ready;
                if (mem.mem_ready) state_d = DECODE;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE:     state_d = EXEC;
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_BEQ:       state_d = BEQ;
`ifdef MC_CTRL_BNE_EN
                    OP_BNE:       state_d = BNE;
`endif
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    OP_JAL:       state_d = JAL;
                    default: begin
                        state_d   = TRAP;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                req_c  = 1'b1;
                iord_c = 1'b1;
                if (mem.mem_ready) state_d = MEMWB;
            end
            MEMWB: begin
                we_reg  = 1'b1;
                dm2reg  = 2'b01;
                state_d = FETCH;
            end
            MEMWR: begin
                req_c  = 1'b1;
                we_c   = 1'b1;
                iord_c = 1'b1;
                if (mem.mem_ready) state_d = FETCH;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = ALUWB;
            end
            ALUWB: begin
                we_reg  = 1'b1;
                reg_dst = 2'b01;
                state_d = FETCH;
            end
            BEQ: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                branch    = 1'b1;
                pc_src    = 2'b01;
                state_d   = FETCH;
            end
`ifdef MC_CTRL_BNE_EN
            BNE: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                branch    = 1'b1;
                branch_ne = 1'b1;
                pc_src    = 2'b01;
                state_d   = FETCH;
            end
`endif
            ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = ADDIWB;
            end
            ADDIWB: begin
                we_reg  = 1'b1;
                state_d = FETCH;
            end
            JUMP: begin
                pc_we   = 1'b1;
                pc_src  = 2'b10;
                state_d = FETCH;
            end
            JAL: begin
                pc_we   = 1'b1;
                pc_src  = 2'b10;
                we_reg  = 1'b1;
                reg_dst = 2'b10;
                dm2reg  = 2'b10;
                state_d = FETCH;
            end
            TRAP: begin
            end
            default: state_d = TRAP;
        endcase

        // Ready always wins over the watchdog because a stall requires mem_ready=0.
        stall    = req_c && !mem.mem_ready;
        wait_inc = (&wait_cnt_q) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
        if (stall && (wait_inc >= MAX_CNT)) begin
            state_d   = TRAP;
            timeout_d = 1'b1;
        end
        if (mem.mem_ready || (state_d != state_q)) wait_cnt_d = '0;
        else if (stall)                            wait_cnt_d = wait_inc;

        if (!rst_n) begin
            req_c     = 1'b0;
            we_c      = 1'b0;
            iord_c    = 1'b0;
            ir_we     = 1'b0;
            pc_we     = 1'b0;
            branch    = 1'b0;
            pc_src    = 2'b00;
            alu_src_a = 1'b0;
            alu_src_b = 2'b00;
            alu_op    = 2'b00;
            we_reg    = 1'b0;
            reg_dst   = 2'b00;
            dm2reg    = 2'b00;
`ifdef MC_CTRL_BNE_EN
            branch_ne = 1'b0;
`endif
            state     = 4'd0;
            illegal   = 1'b0;
            timeout   = 1'b0;
        end
    end

    assign mem.mem_req = req_c;
    assign mem.mem_we  = we_c;
    assign mem.iord    = iord_c;

endmodule
